consumer_fsm: RTL and testbench

CONSUMER_FSM -- requirements
Module: consumer_fsm

---
 rtl/consumer_fsm_pkg.sv | 24 ++
 rtl/consumer_fsm_fifo.sv | 64 ++++++
 rtl/consumer_fsm.sv | 129 ++++++++++++
 tb/tb_consumer_fsm.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/consumer_fsm_pkg.sv
// consumer_fsm_pkg: shared defaults and arbiter state encoding for the consumer pipeline
//   DATA_W_DEF / DEPTH_DEF : default result-word width and per-lane FIFO depth
//   arb_state_e            : round-robin preference (PREF_L1 is the reset state)
package consumer_fsm_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 4;

   typedef enum logic {
      PREF_L1 = 1'b0,
      PREF_L2 = 1'b1
   } arb_state_e;

   // Stall one slot before full so a word already in flight still fits.
   function automatic int stall_thresh_default(input int depth);
      return depth - 1;
   endfunction

   // After a load the preference moves to the lane that was not served.
   function automatic arb_state_e other_lane(input logic took_l2);
      return took_l2 ? PREF_L1 : PREF_L2;
   endfunction

endpackage

// File: rtl/consumer_fsm_fifo.sv
// consumer_fifo: per-lane result buffer with single-cycle flush
//   clk, reset           : clock, asynchronous active-high reset
//   push, din            : write request and word
//   pop                  : remove head (dout) this cycle
//   flush                : empty the buffer; a same-cycle push is discarded
//   dout                 : head word
//   full, empty, count   : occupancy status
//   wr_ok                : the push was written this cycle
module consumer_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic                     full,
   output logic                     empty,
   output logic                     wr_ok,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              rd;

   always_comb begin
      full     = count_q == (AW+1)'(DEPTH);
      empty    = count_q == '0;
      rd       = pop && !empty && !flush;
      // A full buffer still accepts a word when its head leaves the same cycle.
      wr_ok    = push && !flush && (!full || rd);
      rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd);
      wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr_ok);
      count_d  = flush ? '0 : count_q + (AW+1)'(wr_ok) - (AW+1)'(rd);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: contents are unreachable while the pointers say empty.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/consumer_fsm.sv
// consumer_fsm: merges two pipeline result lanes into one registered sink stream
//   clk, reset                    : clock, asynchronous active-high reset
//   pipeline1/2_outputs, out_valid : lane result words and their qualifiers
//   flush_1, flush_2               : clear the corresponding lane buffer
//   sink_ready / sink_valid, sink_data, sink_lane : downstream handshake
//   global_stall                   : registered back-pressure to producers
//   overflow_err                   : sticky per-lane drop flags
//   lane1_count, lane2_count       : wrapping accepted-word counters
module consumer_fsm
   import consumer_fsm_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int DEPTH        = DEPTH_DEF,
   parameter int STALL_THRESH = stall_thresh_default(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] pipeline1_outputs,
   input  logic [DATA_W-1:0] pipeline2_outputs,
   input  logic [1:0]        out_valid,
   input  logic              flush_1,
   input  logic              flush_2,
   input  logic              sink_ready,
   output logic              sink_valid,
   output logic [DATA_W-1:0] sink_data,
   output logic              sink_lane,
   output logic              global_stall,
   output logic [1:0]        overflow_err,
   output logic [15:0]       lane1_count,
   output logic [15:0]       lane2_count
);

   localparam int             CW     = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]  THRESH = CW'(STALL_THRESH);

   logic [DATA_W-1:0] dout1, dout2;
   logic              full1, full2, empty1, empty2, wr1, wr2;
   logic [CW-1:0]     cnt1, cnt2, occ1_n, occ2_n;
   logic              avail1, avail2, can_load, take_l2, load, pop1, pop2;

   arb_state_e        arb_q, arb_d;
   logic              sink_valid_q, sink_valid_d;
   logic [DATA_W-1:0] sink_data_q, sink_data_d;
   logic              sink_lane_q, sink_lane_d;
   logic              stall_q, stall_d;
   logic [1:0]        ovf_q, ovf_d;
   logic [15:0]       c1_q, c1_d, c2_q, c2_d;

   consumer_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane1 (
      .clk   (clk),
      .reset (reset),
      .push  (out_valid[0]),
      .pop   (pop1),
      .flush (flush_1),
      .din   (pipeline1_outputs),
      .dout  (dout1),
      .full  (full1),
      .empty (empty1),
      .wr_ok (wr1),
      .count (cnt1)
   );

   consumer_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane2 (
      .clk   (clk),
      .reset (reset),
      .push  (out_valid[1]),
      .pop   (pop2),
      .flush (flush_2),
      .din   (pipeline2_outputs),
      .dout  (dout2),
      .full  (full2),
      .empty (empty2),
      .wr_ok (wr2),
      .count (cnt2)
   );

   always_comb begin
      // A lane being flushed this cycle offers nothing to the output stage.
      avail1       = !empty1 && !flush_1;
      avail2       = !empty2 && !flush_2;
      can_load     = !sink_valid_q || sink_ready;
      take_l2      = (avail1 && avail2) ? (arb_q == PREF_L2) : avail2;
      load         = can_load && (avail1 || avail2);
      pop1         = load && !take_l2;
      pop2         = load && take_l2;
      sink_valid_d = load || (sink_valid_q && !sink_ready);
      sink_data_d  = load ? (take_l2 ? dout2 : dout1) : sink_data_q;
      sink_lane_d  = load ? take_l2 : sink_lane_q;
      arb_d        = load ? other_lane(take_l2) : arb_q;
      occ1_n       = flush_1 ? '0 : cnt1 + CW'(wr1) - CW'(pop1);
      occ2_n       = flush_2 ? '0 : cnt2 + CW'(wr2) - CW'(pop2);
      stall_d      = (occ1_n >= THRESH) || (occ2_n >= THRESH);
      ovf_d        = ovf_q | {out_valid[1] && !flush_2 && full2 && !pop2,
                              out_valid[0] && !flush_1 && full1 && !pop1};
      c1_d         = c1_q + 16'(wr1);
      c2_d         = c2_q + 16'(wr2);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         arb_q        <= PREF_L1;
         sink_valid_q <= 1'b0;
         sink_data_q  <= '0;
         sink_lane_q  <= 1'b0;
         stall_q      <= 1'b0;
         ovf_q        <= 2'b00;
         c1_q         <= '0;
         c2_q         <= '0;
      end else begin
         arb_q        <= arb_d;
         sink_valid_q <= sink_valid_d;
         sink_data_q  <= sink_data_d;
         sink_lane_q  <= sink_lane_d;
         stall_q      <= stall_d;
         ovf_q        <= ovf_d;
         c1_q         <= c1_d;
         c2_q         <= c2_d;
      end
   end

   assign sink_valid   = sink_valid_q;
   assign sink_data    = sink_data_q;
   assign sink_lane    = sink_lane_q;
   assign global_stall = stall_q;
   assign overflow_err = ovf_q;
   assign lane1_count  = c1_q;
   assign lane2_count  = c2_q;

endmodule

// File: tb/tb_consumer_fsm.sv
// tb_consumer_fsm: directed and randomized checks of consumer_fsm against a queue-based model
module tb_consumer_fsm;

   localparam int DEPTH  = 4;
   localparam int THRESH = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pipeline1_outputs, pipeline2_outputs;
   logic [1:0]  out_valid;
   logic        flush_1, flush_2, sink_ready;
   logic        sink_valid, sink_lane, global_stall;
   logic [31:0] sink_data;
   logic [1:0]  overflow_err;
   logic [15:0] lane1_count, lane2_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        lane;
      logic [31:0] data;
   } xfer_t;
   xfer_t xq[$];

   logic [31:0] q1[$], q2[$];
   logic        m_v, m_l, m_pref, m_stall;
   logic [31:0] m_d;
   logic [1:0]  m_ovf;
   logic [15:0] m_c1, m_c2;

   consumer_fsm dut (
      .clk               (clk),
      .reset             (reset),
      .pipeline1_outputs (pipeline1_outputs),
      .pipeline2_outputs (pipeline2_outputs),
      .out_valid         (out_valid),
      .flush_1           (flush_1),
      .flush_2           (flush_2),
      .sink_ready        (sink_ready),
      .sink_valid        (sink_valid),
      .sink_data         (sink_data),
      .sink_lane         (sink_lane),
      .global_stall      (global_stall),
      .overflow_err      (overflow_err),
      .lane1_count       (lane1_count),
      .lane2_count       (lane2_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      q1.delete();
      q2.delete();
      m_v = 0; m_l = 0; m_d = '0; m_pref = 0; m_stall = 0;
      m_ovf = 2'b00; m_c1 = '0; m_c2 = '0;
   endfunction

   // One clock of the consumer, from the behavioural rules: serve a lane into the
   // output slot if the slot is free or handing off, then accept arrivals.
   function automatic void model_step();
      logic a1, a2, take;
      a1 = q1.size() != 0 && !flush_1;
      a2 = q2.size() != 0 && !flush_2;
      if ((!m_v || sink_ready) && (a1 || a2)) begin
         take = (a1 && a2) ? m_pref : a2;
         m_d = take ? q2.pop_front() : q1.pop_front();
         m_v = 1;
         m_l = take;
         m_pref = !take;
      end else if (sink_ready) m_v = 0;
      if (flush_1) q1.delete();
      else if (out_valid[0]) begin
         if (q1.size() < DEPTH) begin q1.push_back(pipeline1_outputs); m_c1++; end
         else m_ovf[0] = 1;
      end
      if (flush_2) q2.delete();
      else if (out_valid[1]) begin
         if (q2.size() < DEPTH) begin q2.push_back(pipeline2_outputs); m_c2++; end
         else m_ovf[1] = 1;
      end
      m_stall = q1.size() >= THRESH || q2.size() >= THRESH;
   endfunction

   task automatic compare_all();
      chk("sink_valid", 64'(sink_valid), 64'(m_v));
      chk("sink_data", 64'(sink_data), 64'(m_d));
      chk("sink_lane", 64'(sink_lane), 64'(m_l));
      chk("global_stall", 64'(global_stall), 64'(m_stall));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      chk("lane1_count", 64'(lane1_count), 64'(m_c1));
      chk("lane2_count", 64'(lane2_count), 64'(m_c2));
   endtask

   task automatic idle_inputs();
      out_valid = 2'b00; flush_1 = 0; flush_2 = 0; sink_ready = 0;
      pipeline1_outputs = '0; pipeline2_outputs = '0;
   endtask

   task automatic cyc();
      if (sink_valid && sink_ready) xq.push_back('{lane: sink_lane, data: sink_data});
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   logic [32:0] exp_order [4];
   logic        bb_seen;
   int          guard;

   initial begin
      exp_order[0] = {1'b0, 32'h10};
      exp_order[1] = {1'b1, 32'h20};
      exp_order[2] = {1'b0, 32'h11};
      exp_order[3] = {1'b1, 32'h21};
      idle_inputs();
      reset = 1;
      model_reset();
      #12;
      compare_all();
      @(posedge clk);
      #1;
      reset = 0;

      // interleaved traffic
      xq.delete();
      sink_ready = 1;
      out_valid = 2'b11; pipeline1_outputs = 32'h10; pipeline2_outputs = 32'h20;
      cyc();
      pipeline1_outputs = 32'h11; pipeline2_outputs = 32'h21;
      cyc();
      out_valid = 2'b00;
      repeat (6) cyc();
      chk("order_count", 64'(xq.size()), 64'd4);
      for (int i = 0; i < 4 && i < xq.size(); i++)
         chk($sformatf("order%0d", i), 64'({xq[i].lane, xq[i].data}), 64'(exp_order[i]));

      // back-pressure with the output slot already occupied by a lane-2 word
      do_reset();
      out_valid = 2'b10; pipeline2_outputs = 32'h55;
      cyc();
      for (int i = 0; i < 4; i++) begin
         out_valid = 2'b01; pipeline1_outputs = 32'hA0 + 32'(i);
         cyc();
         if (i == 1) chk("stall_below_thresh", 64'(global_stall), 64'd0);
         if (i == 2) chk("stall_at_thresh", 64'(global_stall), 64'd1);
      end
      pipeline1_outputs = 32'hA4;
      cyc();
      chk("overflow_lane1", 64'(overflow_err), 64'd1);
      chk("lane1_count_at_overflow", 64'(lane1_count), 64'd4);
      out_valid = 2'b00;

      // hold stability, then a single handoff
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("hold_data", 64'(sink_data), 64'h55);
         chk("hold_valid", 64'(sink_valid), 64'd1);
      end
      xq.delete();
      sink_ready = 1;
      cyc();
      sink_ready = 0;
      cyc();
      chk("hold_xfer_count", 64'(xq.size()), 64'd1);
      if (xq.size() > 0) chk("hold_xfer_data", 64'(xq[0].data), 64'h55);
      chk("after_handoff_data", 64'(sink_data), 64'hA0);

      // flush colliding with a push on the same lane
      do_reset();
      for (int i = 0; i < 3; i++) begin
         out_valid = 2'b10; pipeline2_outputs = 32'h30 + 32'(i);
         cyc();
      end
      flush_2 = 1; pipeline2_outputs = 32'hBB;
      cyc();
      flush_2 = 0; out_valid = 2'b00;
      chk("flush_count_kept", 64'(lane2_count), 64'd3);
      chk("flush_keeps_output", 64'(sink_data), 64'h30);
      xq.delete();
      sink_ready = 1;
      repeat (4) cyc();
      chk("flush_drain_count", 64'(xq.size()), 64'd1);
      bb_seen = 0;
      foreach (xq[i]) if (xq[i].data == 32'hBB) bb_seen = 1;
      chk("flush_bb_absent", 64'(bb_seen), 64'd0);

      // reset mid-traffic takes effect without a clock edge
      do_reset();
      for (int i = 0; i < 3; i++) begin
         out_valid = 2'b11;
         pipeline1_outputs = $urandom; pipeline2_outputs = $urandom;
         cyc();
      end
      idle_inputs();
      #2;
      reset = 1;
      #1;
      model_reset();
      compare_all();
      chk("async_reset_valid", 64'(sink_valid), 64'd0);
      @(posedge clk);
      #1;
      reset = 0;
      sink_ready = 1; out_valid = 2'b10; pipeline2_outputs = 32'h77;
      cyc();
      chk("post_reset_lat1", 64'(sink_valid), 64'd0);
      out_valid = 2'b00;
      cyc();
      chk("post_reset_lat2_valid", 64'(sink_valid), 64'd1);
      chk("post_reset_lat2_data", 64'(sink_data), 64'h77);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         out_valid = 2'($urandom_range(0, 3));
         pipeline1_outputs = $urandom;
         pipeline2_outputs = $urandom;
         sink_ready = (i % 600 < 300) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
         flush_1 = $urandom_range(0, 31) == 0;
         flush_2 = $urandom_range(0, 31) == 0;
         cyc();
      end

      // counter wrap on lane 1
      do_reset();
      sink_ready = 1; out_valid = 2'b01;
      guard = 0;
      while (m_c1 != 16'hFFFF && guard < 70000) begin
         pipeline1_outputs = 32'(guard);
         cyc();
         guard++;
      end
      chk("wrap_preload", 64'(lane1_count), 64'hFFFF);
      cyc();
      chk("wrap_to_zero", 64'(lane1_count), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
